// File: rtl/chrono_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding,
// display limits and a small state-classification helper.
package chrono_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LAP   = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  function automatic logic is_counting(input logic [1:0] s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/chrono_edge.sv
// Rising-edge detector for one debounced button level. The history flop
// resets high so a button held through reset must be released before it fires.
module chrono_edge
  import chrono_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/chrono_ctrl.sv
// Stopwatch control: button edge detection, run/lap/pause/idle sequencing,
// count-tick prescaler and display source selection.
module chrono_ctrl
  import chrono_pkg::*;
#(
  parameter int CLK_FPGA    = 100000000,
  parameter int CLK_DIV     = 5000000,
  parameter int STOP_AT_MAX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        restart,
  input  logic        lap,
  input  logic [15:0] live_value,
  input  logic        max_reached,
  output logic        tick_en,
  output logic        clear,
  output logic [15:0] disp_value,
  output logic        running,
  output logic [1:0]  state
);

  localparam int              PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic            STOP_EN   = (STOP_AT_MAX != 0);

  if (CLK_DIV < 2 || CLK_FPGA < 1) begin : g_param_check
    $error("chrono_ctrl: CLK_DIV must be at least 2");
  end

  logic ev_start;
  logic ev_stop;
  logic ev_restart;
  logic ev_lap;

  chrono_edge u_edge_start   (.clk(clk), .rst(rst), .level(start),   .rise(ev_start));
  chrono_edge u_edge_stop    (.clk(clk), .rst(rst), .level(stop),    .rise(ev_stop));
  chrono_edge u_edge_restart (.clk(clk), .rst(rst), .level(restart), .rise(ev_restart));
  chrono_edge u_edge_lap     (.clk(clk), .rst(rst), .level(lap),     .rise(ev_lap));

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lap_q,   lap_d;
  logic          tick_q,  tick_d;
  logic          clear_q, clear_d;

  logic max_hold;
  logic counting;
  logic wrap;

  assign max_hold = STOP_EN & max_reached;

  // Events are checked in priority order restart > stop > start > lap;
  // the first one that matters in the current state wins, the rest are dropped.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_restart) begin
          clear_d = 1'b1;
        end else if (ev_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_LAP: begin
        if (ev_restart) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev_stop) begin
          state_d = ST_PAUSE;
        end else if (ev_lap) begin
          if (state_q == ST_RUN) begin
            state_d = ST_LAP;
            lap_d   = live_value;
          end else begin
            state_d = ST_RUN;
          end
        end else if (max_hold) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (ev_restart) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev_start && !max_hold) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only count on edges that both start and stay in RUN/LAP, so a pause keeps
  // the partial period and no tick escapes on an edge that stops counting.
  always_comb begin
    counting = is_counting(state_q) && is_counting(state_d);
    wrap     = counting && (presc_q == PRESC_MAX);
    tick_d   = wrap;
    if (state_d == ST_IDLE) begin
      presc_d = '0;
    end else if (!counting) begin
      presc_d = presc_q;
    end else if (wrap) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      lap_q   <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  assign tick_en    = tick_q;
  assign clear      = clear_q;
  assign state      = state_q;
  assign running    = is_counting(state_q);
  assign disp_value = (state_q == ST_LAP) ? lap_q : live_value;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed bench for chrono_ctrl with CLK_DIV=4 and STOP_AT_MAX=1.
module tb_chrono_ctrl;
  import chrono_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        restart;
  logic        lap;
  logic [15:0] live_value;
  logic        max_reached;
  logic        tick_en;
  logic        clear;
  logic [15:0] disp_value;
  logic        running;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  chrono_ctrl #(.CLK_FPGA(100000000), .CLK_DIV(4), .STOP_AT_MAX(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .restart(restart),
    .lap(lap), .live_value(live_value), .max_reached(max_reached),
    .tick_en(tick_en), .clear(clear), .disp_value(disp_value),
    .running(running), .state(state)
  );

  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; stop = 1'b0; restart = 1'b0; lap = 1'b0;
    live_value = 16'h0042; max_reached = 1'b0;
    step(2);
    n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("[TB] FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    n_cmp++; if ({tick_en, clear, running} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_outs: got %b want 000", {tick_en, clear, running}); end
    n_cmp++; if (disp_value !== 16'h0042) begin n_bad++; $display("[TB] FAIL reset_disp: got %h want 0042", disp_value); end
    rst = 1'b1;
    step(3);
    n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("[TB] FAIL held_start: got %0d want %0d", state, ST_IDLE); end
  endtask

  task automatic test_idle_restart();
    start = 1'b0; stop = 1'b1; lap = 1'b1;
    step(1);
    n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("[TB] FAIL idle_ignore: got %0d want %0d", state, ST_IDLE); end
    stop = 1'b0; lap = 1'b0; restart = 1'b1;
    step(1);
    n_cmp++; if ({state, clear} !== {ST_IDLE, 1'b1}) begin n_bad++; $display("[TB] FAIL idle_restart: got %b want %b", {state, clear}, {ST_IDLE, 1'b1}); end
    restart = 1'b0;
    step(1);
    n_cmp++; if (clear !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_clear_len: got %b want 0", clear); end
  endtask

  task automatic test_start_ticks();
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if ({state, running, tick_en} !== {ST_RUN, 1'b1, 1'b0}) begin n_bad++; $display("[TB] FAIL start_run: got %b want %b", {state, running, tick_en}, {ST_RUN, 2'b10}); end
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_cmp++; if (tick_en !== ((k == 4) || (k == 8))) begin n_bad++; $display("[TB] FAIL tick_cycle%0d: got %b want %b", k, tick_en, ((k == 4) || (k == 8))); end
    end
  endtask

  task automatic test_pause_resume();
    step(2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_cmp++; if ({state, tick_en} !== {ST_PAUSE, 1'b0}) begin n_bad++; $display("[TB] FAIL stop_pause: got %b want %b", {state, tick_en}, {ST_PAUSE, 1'b0}); end
    for (int k = 0; k < 10; k++) begin
      step(1);
      n_cmp++; if (tick_en !== 1'b0) begin n_bad++; $display("[TB] FAIL pause_tick%0d: got %b want 0", k, tick_en); end
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if ({state, tick_en} !== {ST_RUN, 1'b0}) begin n_bad++; $display("[TB] FAIL resume: got %b want %b", {state, tick_en}, {ST_RUN, 1'b0}); end
    step(1);
    n_cmp++; if (tick_en !== 1'b0) begin n_bad++; $display("[TB] FAIL resume_early: got %b want 0", tick_en); end
    step(1);
    n_cmp++; if (tick_en !== 1'b1) begin n_bad++; $display("[TB] FAIL resume_tick: got %b want 1", tick_en); end
  endtask

  task automatic test_lap();
    live_value = 16'h0123; lap = 1'b1;
    step(1);
    lap = 1'b0;
    n_cmp++; if ({state, running} !== {ST_LAP, 1'b1}) begin n_bad++; $display("[TB] FAIL lap_state: got %b want %b", {state, running}, {ST_LAP, 1'b1}); end
    n_cmp++; if (disp_value !== 16'h0123) begin n_bad++; $display("[TB] FAIL lap_disp0: got %h want 0123", disp_value); end
    live_value = 16'h0124;
    step(1);
    n_cmp++; if (disp_value !== 16'h0123) begin n_bad++; $display("[TB] FAIL lap_disp1: got %h want 0123", disp_value); end
    live_value = 16'h0125;
    step(1);
    n_cmp++; if (disp_value !== 16'h0123) begin n_bad++; $display("[TB] FAIL lap_disp2: got %h want 0123", disp_value); end
    step(1);
    n_cmp++; if (tick_en !== 1'b1) begin n_bad++; $display("[TB] FAIL lap_tick: got %b want 1", tick_en); end
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    n_cmp++; if ({state, disp_value} !== {ST_RUN, 16'h0125}) begin n_bad++; $display("[TB] FAIL lap_exit: got %h want %h", {state, disp_value}, {ST_RUN, 16'h0125}); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; stop = 1'b1; restart = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0; restart = 1'b0;
    n_cmp++; if ({state, clear, tick_en} !== {ST_IDLE, 2'b10}) begin n_bad++; $display("[TB] FAIL multi_restart: got %b want %b", {state, clear, tick_en}, {ST_IDLE, 2'b10}); end
    step(1);
    n_cmp++; if ({clear, tick_en} !== 2'b00) begin n_bad++; $display("[TB] FAIL multi_clear_len: got %b want 00", {clear, tick_en}); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_cmp++; if (tick_en !== (k == 4)) begin n_bad++; $display("[TB] FAIL presc_zero%0d: got %b want %b", k, tick_en, (k == 4)); end
    end
  endtask

  task automatic test_max();
    live_value = BCD_MAX; max_reached = 1'b1;
    step(1);
    n_cmp++; if ({state, tick_en} !== {ST_PAUSE, 1'b0}) begin n_bad++; $display("[TB] FAIL max_pause: got %b want %b", {state, tick_en}, {ST_PAUSE, 1'b0}); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (state !== ST_PAUSE) begin n_bad++; $display("[TB] FAIL max_start: got %0d want %0d", state, ST_PAUSE); end
    restart = 1'b1;
    step(1);
    restart = 1'b0; max_reached = 1'b0;
    n_cmp++; if ({state, clear} !== {ST_IDLE, 1'b1}) begin n_bad++; $display("[TB] FAIL max_restart: got %b want %b", {state, clear}, {ST_IDLE, 1'b1}); end
    step(1);
    n_cmp++; if (clear !== 1'b0) begin n_bad++; $display("[TB] FAIL max_clear_len: got %b want 0", clear); end
  endtask

  task automatic test_reset_mid_lap();
    start = 1'b1;
    step(1);
    start = 1'b0; live_value = 16'h0300; lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(2);
    n_cmp++; if ({state, disp_value} !== {ST_LAP, 16'h0300}) begin n_bad++; $display("[TB] FAIL prelap: got %h want %h", {state, disp_value}, {ST_LAP, 16'h0300}); end
    rst = 1'b0; live_value = 16'h0311;
    step(1);
    n_cmp++; if ({state, tick_en, clear, running} !== {ST_IDLE, 3'b000}) begin n_bad++; $display("[TB] FAIL midlap_reset: got %b want %b", {state, tick_en, clear, running}, {ST_IDLE, 3'b000}); end
    n_cmp++; if (disp_value !== 16'h0311) begin n_bad++; $display("[TB] FAIL midlap_disp: got %h want 0311", disp_value); end
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_restart();
    test_start_ticks();
    test_pause_resume();
    test_lap();
    test_back_to_back();
    test_max();
    test_reset_mid_lap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chrono_ctrl.md
Name: chrono_ctrl

Overview:
- Control FSM for the stopwatch datapath.
- Takes debounced start/stop/restart/lap button levels and sequences the counter: run, pause, clear and lap-freeze.
- Generates the gated count tick from the system clock and selects the value shown on the 7-segment display: live count or frozen lap value.
- Sits between the debouncers and the counter/display blocks and replaces ad-hoc gating in the top level.

Parameters:
- CLK_FPGA, 100000000, system clock frequency in Hz (documentation only; no logic depends on it)
- CLK_DIV, 5000000, clk cycles per count tick; legal range ≥ 2
- STOP_AT_MAX, 1, if 1, max_reached forces PAUSE; if 0, the counter is allowed to wrap

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  debounced start button level
- stop  in  1  debounced stop button level
- restart  in  1  debounced restart button level
- lap  in  1  debounced lap button level
- live_value  in  16  current counter value (4 BCD digits)
- max_reached  in  1  counter is at 99.99 (level)
- tick_en  out  1  one-cycle count-enable strobe to the counter
- clear  out  1  one-cycle synchronous clear to the counter
- disp_value  out  16  value to display driver
- running  out  1  high in RUN or LAP
- state  out  2  current FSM state, for debug LEDs

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; tick_en=0; clear=0; lap_reg=0; prescaler=0.
  - Button history registers reset to 1. A button held through reset does not fire; it must be released and pressed again.
- Edge detection:
  - ev_x = x & ~x_prev, combinational.
  - x_prev is updated every cycle.
  - An event is acted on at the same clk edge at which x is first sampled high.
- Simultaneous events: priority restart > stop > start > lap. Only the highest-priority event is acted on; the others are discarded (not queued).
- States: IDLE=0, RUN=1, LAP=2, PAUSE=3.
- IDLE:
  - ev_start -> RUN, prescaler cleared to 0.
  - ev_restart -> clear pulse, stay IDLE.
  - stop and lap are ignored.
- RUN:
  - ev_restart -> IDLE + clear.
  - ev_stop -> PAUSE.
  - ev_lap -> LAP, lap_reg <= live_value at that edge.
  - If STOP_AT_MAX=1 and max_reached=1 with no higher-priority event -> PAUSE.
- LAP:
  - Counting continues and the display is frozen.
  - ev_restart -> IDLE + clear.
  - ev_stop -> PAUSE.
  - ev_lap -> RUN (display returns to live).
  - max_reached rule is the same as in RUN.
- PAUSE:
  - ev_start -> RUN. Prescaler is NOT cleared; the partial tick period resumes.
  - ev_restart -> IDLE + clear.
  - stop and lap are ignored.
  - With STOP_AT_MAX=1 and max_reached still high, ev_start is ignored (stays PAUSE).
- Prescaler:
  - Width $clog2(CLK_DIV).
  - Counts only in RUN/LAP; holds its value in PAUSE; is 0 in IDLE.
  - On the edge where it equals CLK_DIV-1, it wraps to 0.
- tick_en:
  - Registered; high for exactly the one cycle following the prescaler wrap edge.
  - First tick after IDLE->RUN arrives CLK_DIV cycles after the transition edge.
  - Never asserted in the cycle following an edge that leaves RUN/LAP.
- clear:
  - Registered; high for exactly one cycle following the restart edge.
  - The prescaler is zeroed at that same edge.
- disp_value: combinational; equals lap_reg when state=LAP, else live_value.
- running: combinational from state (RUN or LAP).

Decomposition:
- Shared package chrono_pkg:
  - state encoding constants (IDLE, RUN, LAP, PAUSE, 2-bit);
  - BCD max constant 16'h9999.
- Sub-module chrono_edge: 1-bit rising-edge detector with history register reset to 1. Instantiated 4 times.
- FSM, prescaler and lap register stay in chrono_ctrl.

Test Plan (CLK_DIV=4, STOP_AT_MAX=1):
1. Reset with start held high, release rst -> state stays IDLE. Release start, then press start -> state=RUN after 1 edge; tick_en pulses every 4 cycles, first pulse 4 cycles after the transition.
2. RUN, press stop with prescaler=2 -> PAUSE, no tick_en. Press start after 10 cycles -> next tick_en exactly 2 cycles after resume.
3. RUN with live_value=16'h0123, press lap -> LAP; disp_value=16'h0123 while live_value advances to 16'h0125; tick_en continues. Press lap again -> RUN, disp_value=live_value.
4. Same cycle start+stop+restart rise in RUN -> IDLE, clear high exactly 1 cycle, prescaler=0, tick_en stays 0.
5. RUN, drive max_reached=1 -> PAUSE on the next edge. Press start while max_reached=1 -> stays PAUSE. Press restart -> IDLE + clear.
6. Assert rst=0 mid-LAP -> next edge: state=IDLE, lap_reg=0, tick_en=0, clear=0, disp_value=live_value.
